// File: rtl/mac_pkg.sv
// mac_pkg: shared types and default widths for the streaming MAC engine.
package mac_pkg;

  // Control states of the vector sequencer
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ACC_W_DEF  = 40;
  localparam int unsigned OUT_W_DEF  = 16;
  localparam int unsigned CNT_W_DEF  = 8;

  // Full signed product width for a given operand width
  function automatic int unsigned prod_w(input int unsigned data_w);
    return 2 * data_w;
  endfunction

endpackage

// File: rtl/mac_narrow.sv
// mac_narrow: combinational ACC_W -> OUT_W result narrower.
// Build option MAC_SATURATE_EN: clamp to the signed OUT_W range instead of wrapping.
module mac_narrow
  import mac_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF
) (
  input  logic [ACC_W-1:0] i_acc,
  output logic [OUT_W-1:0] o_data_c
);

`ifdef MAC_SATURATE_EN
  logic [ACC_W-OUT_W:0] w_hi;
  logic                 w_fits;

  // Value fits when every bit from the OUT_W sign position upward agrees
  assign w_hi   = i_acc[ACC_W-1:OUT_W-1];
  assign w_fits = (&w_hi) | ~(|w_hi);

  // Clamp toward the sign of the accumulator when out of range
  always_comb begin
    o_data_c = i_acc[OUT_W-1:0];
    if (!w_fits) begin
      o_data_c = i_acc[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
`else
  logic w_unused_hi;

  // Plain truncation; upper accumulator bits are intentionally dropped
  assign w_unused_hi = ^i_acc;
  assign o_data_c    = i_acc[OUT_W-1:0];
`endif

endmodule

// File: rtl/mac_stream.sv
// mac_stream: handshaked signed multiply-accumulate, one dot product per vector.
// Two-stage pipeline (multiply, accumulate); out_data narrowing selected by
// MAC_SATURATE_EN (saturate when defined, wrap otherwise).
module mac_stream
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned OUT_W  = OUT_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [CNT_W-1:0]  len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [ACC_W-1:0]  out_acc,
  output logic              busy
);

  localparam int unsigned PROD_W = prod_w(DATA_W);

  state_t r_state;
  state_t w_state_nxt;

  logic                     r_in_ready;
  logic                     r_out_valid;
  logic                     r_busy;
  logic [CNT_W-1:0]         r_len;
  logic [CNT_W-1:0]         r_cnt;
  logic [CNT_W-1:0]         w_len_eff;
  logic [CNT_W-1:0]         w_cnt_inc;
  logic                     w_accept;
  logic signed [PROD_W-1:0] w_a_ext;
  logic signed [PROD_W-1:0] w_b_ext;
  logic signed [PROD_W-1:0] w_prod;
  logic [PROD_W-1:0]        r_prod;
  logic                     r_prod_vld;
  logic                     r_prod_first;
  logic [ACC_W-1:0]         w_prod_ext;
  logic [ACC_W-1:0]         w_acc_nxt;
  logic [ACC_W-1:0]         r_acc;
  logic [ACC_W-1:0]         r_out_acc;
  logic [OUT_W-1:0]         r_out_data;
  logic [OUT_W-1:0]         w_narrow;

  assign w_accept  = in_valid & r_in_ready;
  assign w_len_eff = (len == '0) ? CNT_W'(1) : len;
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  assign w_a_ext = PROD_W'($signed(a));
  assign w_b_ext = PROD_W'($signed(b));
  assign w_prod  = w_a_ext * w_b_ext;

  // First product of a vector loads the accumulator; later ones add
  assign w_prod_ext = ACC_W'($signed(r_prod));
  assign w_acc_nxt  = r_prod_first ? w_prod_ext : (r_acc + w_prod_ext);

  // Next-state logic for the vector sequencer
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (w_len_eff == CNT_W'(1)) ? ST_DRAIN : ST_ACC;
        end
      end
      ST_ACC: begin
        if (w_accept && (w_cnt_inc == r_len)) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: w_state_nxt = ST_OUT;
      ST_OUT: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register with handshake/status flags decoded from the next state
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_ACC);
      r_out_valid <= (w_state_nxt == ST_OUT);
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  // Vector length latch and beat counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_len <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      if (r_state == ST_IDLE) begin
        r_len <= w_len_eff;
        r_cnt <= CNT_W'(1);
      end else begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

  // Stage 1: register the full-width product of each accepted beat
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_prod       <= '0;
      r_prod_vld   <= 1'b0;
      r_prod_first <= 1'b0;
    end else begin
      r_prod_vld   <= w_accept;
      r_prod_first <= w_accept && (r_state == ST_IDLE);
      if (w_accept) begin
        r_prod <= w_prod;
      end
    end
  end

  // Stage 2: accumulate, wrapping modulo 2^ACC_W
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_acc <= '0;
    end else if (r_prod_vld) begin
      r_acc <= w_acc_nxt;
    end
  end

  mac_narrow #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_narrow (
    .i_acc    (w_acc_nxt),
    .o_data_c (w_narrow)
  );

  // Capture the result as the final product lands; held through OUT
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out_acc  <= '0;
      r_out_data <= '0;
    end else if (r_state == ST_DRAIN) begin
      r_out_acc  <= w_acc_nxt;
      r_out_data <= w_narrow;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_acc   = r_out_acc;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mac_stream.sv
// tb_mac_stream: directed self-checking bench for mac_stream (default widths).
// Expected narrowed values follow MAC_SATURATE_EN when the bench is built with it.
module tb_mac_stream;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [7:0]  len;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [39:0] out_acc;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  mac_stream dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .len       (len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_acc   (out_acc),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one beat for a single edge; in_ready is known high in IDLE/ACC
  task automatic beat(input logic [15:0] va, input logic [15:0] vb, input logic [7:0] vl);
    a        = va;
    b        = vb;
    len      = vl;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hs_out_valid", out_valid, 1'b0);
    chk("hs_in_ready", in_ready, 1'b1);
    chk("hs_busy", busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_pos;
    logic [15:0] exp_neg;
`ifdef MAC_SATURATE_EN
    exp_pos = 16'h7FFF;
    exp_neg = 16'h8000;
`else
    exp_pos = 16'h0002;
    exp_neg = 16'h0000;
`endif

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; len = '0;
    tick(); tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_data", out_data, 16'h0000);
    chk("rst_out_acc", out_acc, 40'h0);
    rst = 1'b1;

    // Reset mid-vector discards the partial vector
    beat(16'd1, 16'd1, 8'd4);
    beat(16'd2, 16'd2, 8'd0);
    chk("midvec_busy", busy, 1'b1);
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    chk("postrst_busy", busy, 1'b0);
    chk("postrst_in_ready", in_ready, 1'b1);
    chk("postrst_out_valid", out_valid, 1'b0);
    beat(16'd3, 16'd5, 8'd1);
    chk("len1_drain_valid", out_valid, 1'b0);
    chk("len1_drain_ready", in_ready, 1'b0);
    tick();
    chk("len1_out_valid", out_valid, 1'b1);
    chk("len1_out_data", out_data, 16'd15);
    chk("len1_out_acc", out_acc, 40'd15);
    handshake();
    tick(); tick();
    chk("no_stale_valid", out_valid, 1'b0);

    // Dot product with in_valid gaps; len only sampled on the first beat
    beat(16'd1, 16'd5, 8'd4);
    tick();
    chk("gap_in_ready", in_ready, 1'b1);
    beat(16'd2, 16'd6, 8'd9);
    beat(16'hFFFD, 16'd7, 8'd0);
    tick(); tick();
    chk("gap_out_valid", out_valid, 1'b0);
    beat(16'd4, 16'hFFF8, 8'd0);
    chk("dot_drain_valid", out_valid, 1'b0);
    tick();
    chk("dot_out_valid", out_valid, 1'b1);
    chk("dot_out_acc", out_acc, 40'hFF_FFFF_FFDC);
    chk("dot_out_data", out_data, 16'hFFDC);

    // Backpressure: result held stable, no new beats taken
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_out_data", out_data, 16'hFFDC);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_busy", busy, 1'b1);
    end

    // Handshake with a new beat presented: not taken in the OUT cycle
    a = 16'hFFFE; b = 16'd7; len = 8'd0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("sim_out_valid", out_valid, 1'b0);
    chk("sim_in_ready", in_ready, 1'b1);
    chk("sim_busy", busy, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("len0_accepted_busy", busy, 1'b1);
    chk("len0_drain_valid", out_valid, 1'b0);
    tick();
    chk("len0_out_valid", out_valid, 1'b1);
    chk("len0_out_data", out_data, 16'hFFF2);
    chk("len0_out_acc", out_acc, 40'hFF_FFFF_FFF2);
    handshake();

    // Positive overflow of the narrow range
    beat(16'h7FFF, 16'h7FFF, 8'd2);
    beat(16'h7FFF, 16'h7FFF, 8'd0);
    tick();
    chk("pos_out_valid", out_valid, 1'b1);
    chk("pos_out_acc", out_acc, 40'h00_7FFE_0002);
    chk("pos_out_data", out_data, exp_pos);
    handshake();

    // Negative overflow of the narrow range
    beat(16'h8000, 16'h7FFF, 8'd2);
    beat(16'h8000, 16'h7FFF, 8'd2);
    tick();
    chk("neg_out_valid", out_valid, 1'b1);
    chk("neg_out_acc", out_acc, 40'hFF_8001_0000);
    chk("neg_out_data", out_data, exp_neg);
    handshake();

    // out_ready held high while idle has no effect; result then pulses once
    out_ready = 1'b1;
    tick(); tick();
    chk("idle_rdy_valid", out_valid, 1'b0);
    chk("idle_rdy_busy", busy, 1'b0);
    beat(16'd1, 16'd1, 8'd3);
    beat(16'd2, 16'd2, 8'd0);
    beat(16'd3, 16'd3, 8'd0);
    tick();
    chk("len3_out_valid", out_valid, 1'b1);
    chk("len3_out_acc", out_acc, 40'd14);
    chk("len3_out_data", out_data, 16'd14);
    tick();
    chk("len3_pulse_end", out_valid, 1'b0);
    chk("len3_in_ready", in_ready, 1'b1);
    out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
